// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch controller.
package stopwatch_pkg;

   localparam int          BCD_MAX  = 9;
   localparam int          DIGITS   = 4;
   localparam logic [15:0] TERMINAL = 16'h9999;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_LAP,
      ST_FULL
   } state_t;

endpackage

// File: rtl/key_edge.sv
// One-bit rising-edge detector; history resets high so a key held through reset yields no event.
module key_edge (
   input  logic CLK,
   input  logic srst,
   input  logic key,
   output logic evt
);

   logic hist_reg;

   always_ff @(posedge CLK) begin
      if (srst) begin
         hist_reg <= 1'b1;
      end else begin
         hist_reg <= key;
      end
   end

   assign evt = key & ~hist_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller driving four cascaded BCD decade counters.
// Optional lap feature enabled by defining STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl
   import stopwatch_pkg::*;
(
   input  logic        CLK,
   input  logic        CR,
   input  logic        TICK,
   input  logic        KEY_SS,
   input  logic        KEY_LAP,
   input  logic        KEY_CLR,
   input  logic [15:0] Q_IN,
   output logic [3:0]  EN,
   output logic        NCR_OUT,
   output logic [15:0] DISP,
   output logic        RUNNING,
   output logic        FULL
);

`ifdef STOPWATCH_CTRL_LAP_EN
   localparam logic LAP_ENABLED = 1'b1;
`else
   localparam logic LAP_ENABLED = 1'b0;
`endif

   logic ss_evt;
   logic lap_evt;
   logic clr_evt;
   logic lap_ok;

   state_t state_reg;
   state_t state_next;
   logic   clr_pulse_reg;
   logic   clr_pulse_next;

   logic              counting;
   logic              terminal;
   logic              term_tick;
   logic [DIGITS-1:0] en_chain;

   key_edge u_ss (
      .CLK  (CLK),
      .srst (CR),
      .key  (KEY_SS),
      .evt  (ss_evt)
   );

   key_edge u_lap (
      .CLK  (CLK),
      .srst (CR),
      .key  (KEY_LAP),
      .evt  (lap_evt)
   );

   key_edge u_clr (
      .CLK  (CLK),
      .srst (CR),
      .key  (KEY_CLR),
      .evt  (clr_evt)
   );

   assign lap_ok    = lap_evt & LAP_ENABLED;
   assign counting  = (state_reg == ST_RUN) || (state_reg == ST_LAP);
   assign terminal  = (Q_IN == TERMINAL);
   assign term_tick = TICK & counting & terminal;

   // Ripple enable: a digit advances only when every lower digit is about to wrap.
   assign en_chain[0] = TICK & counting & ~terminal & ~CR;
   generate
      for (genvar gi = 1; gi < DIGITS; gi++) begin : g_en
         assign en_chain[gi] = en_chain[gi-1] & (Q_IN[4*(gi-1) +: 4] == 4'(BCD_MAX));
      end
   endgenerate
   assign EN = en_chain;

   // Ignored events do not block lower-priority ones; only events meaningful in the state compete.
   always_comb begin
      state_next     = state_reg;
      clr_pulse_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (clr_evt) begin
               clr_pulse_next = 1'b1;
            end else if (ss_evt) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (term_tick) begin
               state_next = ST_FULL;
            end else if (ss_evt) begin
               state_next = ST_PAUSE;
            end else if (lap_ok) begin
               state_next = ST_LAP;
            end
         end
         ST_PAUSE: begin
            if (clr_evt) begin
               state_next     = ST_IDLE;
               clr_pulse_next = 1'b1;
            end else if (ss_evt) begin
               state_next = ST_RUN;
            end
         end
         ST_LAP: begin
            if (term_tick) begin
               state_next = ST_FULL;
            end else if (ss_evt) begin
               state_next = ST_PAUSE;
            end else if (lap_ok) begin
               state_next = ST_RUN;
            end
         end
         ST_FULL: begin
            if (clr_evt) begin
               state_next     = ST_IDLE;
               clr_pulse_next = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CR) begin
         state_reg     <= ST_IDLE;
         clr_pulse_reg <= 1'b1;
      end else begin
         state_reg     <= state_next;
         clr_pulse_reg <= clr_pulse_next;
      end
   end

   assign NCR_OUT = ~clr_pulse_reg;
   assign RUNNING = counting & ~CR;
   assign FULL    = (state_reg == ST_FULL) & ~CR;

`ifdef STOPWATCH_CTRL_LAP_EN
   logic [15:0] lap_reg;

   always_ff @(posedge CLK) begin
      if (CR) begin
         lap_reg <= 16'h0000;
      end else if ((state_reg == ST_RUN) && (state_next == ST_LAP)) begin
         lap_reg <= Q_IN;
      end
   end

   assign DISP = ((state_reg == ST_LAP) && !CR) ? lap_reg : Q_IN;
`else
   assign DISP = Q_IN;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized keys/ticks vs a behavioural model.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_CTRL_LAP_EN
   localparam bit LAP_ON = 1'b1;
`else
   localparam bit LAP_ON = 1'b0;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_LAP   = 3;
   localparam int M_FULL  = 4;

   logic        clk = 1'b0;
   logic        cr, tick, key_ss, key_lap, key_clr;
   logic [15:0] q_in;
   logic [3:0]  en;
   logic        ncr_out, running, full;
   logic [15:0] disp;

   always #5 clk = ~clk;

   stopwatch_ctrl dut (
      .CLK     (clk),
      .CR      (cr),
      .TICK    (tick),
      .KEY_SS  (key_ss),
      .KEY_LAP (key_lap),
      .KEY_CLR (key_clr),
      .Q_IN    (q_in),
      .EN      (en),
      .NCR_OUT (ncr_out),
      .DISP    (disp),
      .RUNNING (running),
      .FULL    (full)
   );

   // Behavioural model: stopwatch mode, lap value, pending clear, previous key levels.
   int   m_state   = M_IDLE;
   int   m_lap_val = 0;
   bit   m_pulse   = 1'b1;
   bit   m_hist_ss = 1'b1, m_hist_lap = 1'b1, m_hist_clr = 1'b1;
   bit   m_valid   = 1'b0;
   int   cnt       = 0;
   int   n_pass    = 0;
   int   n_checks  = 0;

   logic [3:0]  s_en;
   logic        s_ncr, s_run, s_full;
   logic [15:0] s_disp;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   // Digit k advances when the value below that place is all nines.
   function automatic logic [3:0] roll_mask(input int v);
      logic [3:0] m;
      int p;
      p = 1;
      for (int k = 0; k < 4; k++) begin
         m[k] = ((v % p) == p - 1);
         p = p * 10;
      end
      return m;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      bit ev_ss, ev_lap, ev_clr, counting, tt;
      int nstate, nlap, orig, p;
      bit npulse;
      logic [3:0]  e_en;
      logic [15:0] e_disp;

      @(negedge clk);
      s_en = en; s_ncr = ncr_out; s_run = running; s_full = full; s_disp = disp;

      ev_ss    = key_ss  & ~m_hist_ss;
      ev_lap   = key_lap & ~m_hist_lap;
      ev_clr   = key_clr & ~m_hist_clr;
      counting = (m_state == M_RUN) || (m_state == M_LAP);
      tt       = tick && counting && (cnt == 9999);

      if (m_valid) begin
         if (cr) begin
            e_en = 4'b0; e_disp = q_in;
         end else begin
            e_en   = (tick && counting && cnt != 9999) ? roll_mask(cnt) : 4'b0;
            e_disp = (m_state == M_LAP) ? to_bcd(m_lap_val) : q_in;
         end
         chk("en", 16'(s_en), 16'(e_en));
         chk("ncr_out", 16'(s_ncr), 16'(!m_pulse));
         chk("disp", s_disp, e_disp);
         chk("running", 16'(s_run), 16'(counting && !cr));
         chk("full", 16'(s_full), 16'((m_state == M_FULL) && !cr));
      end

      nstate = m_state; nlap = m_lap_val; npulse = 1'b0;
      if (cr) begin
         nstate = M_IDLE; nlap = 0; npulse = 1'b1;
      end else begin
         case (m_state)
            M_IDLE:  if (ev_clr) npulse = 1'b1; else if (ev_ss) nstate = M_RUN;
            M_RUN:   if (tt) nstate = M_FULL;
                     else if (ev_ss) nstate = M_PAUSE;
                     else if (ev_lap && LAP_ON) begin nstate = M_LAP; nlap = cnt; end
            M_PAUSE: if (ev_clr) begin nstate = M_IDLE; npulse = 1'b1; end
                     else if (ev_ss) nstate = M_RUN;
            M_LAP:   if (tt) nstate = M_FULL;
                     else if (ev_ss) nstate = M_PAUSE;
                     else if (ev_lap) nstate = M_RUN;
            M_FULL:  if (ev_clr) begin nstate = M_IDLE; npulse = 1'b1; end
            default: nstate = M_IDLE;
         endcase
      end

      @(posedge clk);
      #1;
      m_state = nstate; m_lap_val = nlap; m_pulse = npulse; m_valid = 1'b1;
      if (cr) begin
         m_hist_ss = 1'b1; m_hist_lap = 1'b1; m_hist_clr = 1'b1;
      end else begin
         m_hist_ss = key_ss; m_hist_lap = key_lap; m_hist_clr = key_clr;
      end

      // External decade counters: synchronous clear, otherwise per-digit enable from the DUT.
      if (s_ncr !== 1'b1) begin
         cnt = 0;
      end else begin
         orig = cnt; p = 1;
         for (int k = 0; k < 4; k++) begin
            if (s_en[k] === 1'b1) cnt = cnt + (((orig / p) % 10 == 9) ? -9 * p : p);
            p = p * 10;
         end
      end
      q_in = to_bcd(cnt);
   endtask

   task automatic press(input int which);
      if (which == 0) key_ss = 1'b1; else if (which == 1) key_lap = 1'b1; else key_clr = 1'b1;
      step();
      key_ss = 1'b0; key_lap = 1'b0; key_clr = 1'b0;
      step();
      $display("press key %0d: running=%b full=%b disp=%h", which, s_run, s_full, s_disp);
   endtask

   task automatic set_cnt(input int v);
      cnt = v; q_in = to_bcd(v);
   endtask

   initial begin
      int pre;
      cr = 1'b1; tick = 1'b0; key_ss = 1'b0; key_lap = 1'b0; key_clr = 1'b0; q_in = 16'h0;
      repeat (3) step();
      chk("rst_en", 16'(s_en), 16'h0);
      cr = 1'b0;
      step();
      chk("rst_release_ncr_low", 16'(s_ncr), 16'h0);
      step();
      chk("ncr_high_after", 16'(s_ncr), 16'h1);

      // Count twelve ticks from zero
      press(0);
      for (int i = 0; i < 12; i++) begin
         pre = cnt; tick = 1'b1; step(); tick = 1'b0;
         if (pre == 9) chk("en_at_0009", 16'(s_en), 16'h3);
         else chk("en1_low", 16'(s_en[1]), 16'h0);
         step();
         $display("tick %0d: en=%b q=%h", i, s_en, q_in);
      end
      chk("q_0012", q_in, 16'h0012);
      chk("disp_0012", s_disp, 16'h0012);
      chk("running_1", 16'(s_run), 16'h1);

      // Carry across two digits
      set_cnt(199); tick = 1'b1; step(); tick = 1'b0;
      chk("en_at_0199", 16'(s_en), 16'h7);
      chk("q_0200", q_in, 16'h0200);
      step();

      if (LAP_ON) begin
         set_cnt(42);
         press(1);
         for (int i = 0; i < 5; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
         end
         chk("lap_disp_0042", s_disp, 16'h0042);
         chk("lap_q_0047", q_in, 16'h0047);
         press(1);
         chk("lap_exit_disp_0047", s_disp, 16'h0047);
      end

      // Terminal tick saturates into FULL
      set_cnt(9999); tick = 1'b1; step(); tick = 1'b0;
      chk("en_at_9999", 16'(s_en), 16'h0);
      step();
      chk("full_set", 16'(s_full), 16'h1);
      press(0);
      chk("full_ignores_ss", 16'(s_full), 16'h1);
      press(2);
      chk("clr_ncr_low", 16'(s_ncr), 16'h0);
      chk("clr_full_low", 16'(s_full), 16'h0);
      step();
      chk("clr_ncr_high", 16'(s_ncr), 16'h1);

      // SS+CLR together in PAUSE, then a held SS key
      press(0); press(0);
      key_ss = 1'b1; key_clr = 1'b1; step(); key_ss = 1'b0; key_clr = 1'b0; step();
      chk("ss_clr_pulse", 16'(s_ncr), 16'h0);
      chk("ss_clr_not_run", 16'(s_run), 16'h0);
      key_ss = 1'b1;
      repeat (20) step();
      chk("held_ss_one_event", 16'(s_run), 16'h1);
      key_ss = 1'b0; step();

      // Reset during operation with SS held
      if (LAP_ON) press(1);
      key_ss = 1'b1; cr = 1'b1; tick = 1'b1;
      step();
      chk("cr_overrides_tick", 16'(s_en), 16'h0);
      step();
      cr = 1'b0;
      repeat (5) step();
      chk("cr_held_ss_no_run", 16'(s_run), 16'h0);
      chk("cr_held_ss_no_en", 16'(s_en), 16'h0);
      key_ss = 1'b0; tick = 1'b0; step();
      press(0);
      chk("ss_after_release_runs", 16'(s_run), 16'h1);

      // Randomized keys, ticks, preloads and occasional reset
      for (int i = 0; i < 3000; i++) begin
         cr   = ($urandom_range(0, 299) == 0);
         tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 5) == 0) key_ss  = ~key_ss;
         if ($urandom_range(0, 7) == 0) key_lap = ~key_lap;
         if ($urandom_range(0, 9) == 0) key_clr = ~key_clr;
         if ($urandom_range(0, 149) == 0) set_cnt($urandom_range(9990, 9999));
         else if ($urandom_range(0, 149) == 0) set_cnt($urandom_range(0, 9999));
         step();
      end
      cr = 1'b0; tick = 1'b0; key_ss = 1'b0; key_lap = 1'b0; key_clr = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have: CLK  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have: CR  input  1  synchronous, active-high reset.
REQ-003 SHALL have: TICK  input  1  one-cycle time-base pulse (e.g. 1 Hz from prescaler).
REQ-004 SHALL have: KEY_SS  input  1  start/stop key, level, already debounced.
REQ-005 SHALL have: KEY_LAP  input  1  lap key, level, already debounced.
REQ-006 SHALL have: KEY_CLR  input  1  clear key, level, already debounced.
REQ-007 SHALL have: Q_IN  input  16  current value of four cascaded decade counters, BCD, digit 0 in [3:0].
REQ-008 SHALL have: EN  output  4  per-digit count enable to decade counters, EN[0] = digit 0.
REQ-009 SHALL have: NCR_OUT  output  1  active-low clear to decade counters.
REQ-010 SHALL have: DISP  output  16  BCD value for display.
REQ-011 SHALL have: RUNNING  output  1  high in RUN and LAP.
REQ-012 SHALL have: FULL  output  1  high in FULL state.

Function
REQ-013 SHALL edge-detect each key: event = KEY high now and low in previous CLK sample; a held key SHALL produce exactly one event.
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, LAP, FULL.
REQ-015 IDLE: SS event -> RUN; CLR event -> IDLE with clear pulse.
REQ-016 RUN: SS event -> PAUSE; LAP event -> LAP; terminal tick -> FULL.
REQ-017 PAUSE: SS event -> RUN; CLR event -> IDLE with clear pulse.
REQ-018 LAP: LAP event -> RUN; SS event -> PAUSE; terminal tick -> FULL; counting continues.
REQ-019 FULL: CLR event -> IDLE with clear pulse; SS and LAP events ignored.
REQ-020 Event priority within one cycle: CLR > SS > LAP; lower-priority events in the same cycle SHALL be discarded.
REQ-021 CLR events in RUN or LAP SHALL be ignored.
REQ-022 Clear pulse: NCR_OUT SHALL be low for exactly the one cycle after the accepting edge, else high.
REQ-023 EN[0] SHALL = TICK & (state is RUN or LAP) & not terminal; terminal means Q_IN == 16'h9999.
REQ-024 EN[k] SHALL = EN[k-1] & (digit k-1 of Q_IN == 9) for k = 1..3; combinational from registered state, zero added latency.
REQ-025 A TICK while Q_IN == 16'h9999 in RUN or LAP SHALL produce EN = 0 and move to FULL; counters hold 9999, no wrap.
REQ-026 On LAP entry, the controller SHALL latch Q_IN into a 16-bit lap register.
REQ-027 DISP SHALL = lap register in LAP, else Q_IN.
REQ-028 TICK and a key event in the same cycle: EN SHALL follow the pre-edge state; the new state applies from the next cycle.

Reset
REQ-029 While CR high at an edge: state <- IDLE, lap register <- 0, key history <- 1 so keys held through reset give no event.
REQ-030 During and the cycle after reset: EN = 0; NCR_OUT = 0 for one cycle after release, then 1; RUNNING = 0; FULL = 0; DISP = Q_IN.
REQ-031 CR mid-operation SHALL override all key events and TICK in that cycle.

Configuration
REQ-032 Macro STOPWATCH_CTRL_LAP_EN defined: LAP state, lap register and KEY_LAP behaviour per REQ-016/018/026/027.
REQ-033 Macro undefined: no LAP state or lap register; KEY_LAP ignored; DISP = Q_IN always; all other behaviour unchanged.

Structure
REQ-034 Shared package stopwatch_pkg SHALL hold state encoding, BCD_MAX (9), DIGITS (4) and TERMINAL (16'h9999).
REQ-035 Sub-module key_edge (one-bit rising-edge detector with reset-to-1 history) SHALL be instantiated once per key.

Verification
REQ-036 Reset, SS event, 12 TICKs with counter model -> Q_IN = 0012, RUNNING = 1, EN[1] high only on tick at 0009.
REQ-037 At Q_IN = 0199 in RUN, TICK -> EN = 4'b0111 that cycle, Q_IN = 0200.
REQ-038 LAP event at 0042, 5 TICKs -> DISP stays 0042, Q_IN = 0047; second LAP -> DISP = 0047.
REQ-039 Q_IN = 9999 in RUN, TICK -> EN = 0, FULL = 1; SS ignored; CLR -> NCR_OUT low one cycle, IDLE, FULL = 0.
REQ-040 SS and CLR together in PAUSE -> IDLE with clear pulse, no RUN; KEY_SS held 20 cycles -> one event only.
REQ-041 CR asserted in LAP with KEY_SS held -> IDLE, EN = 0, no event after CR release until KEY_SS low then high.
